pwm_audio_mc: RTL and testbench
===============================

PWM_AUDIO_MC -- requirements
Module: pwm_audio_mc

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, number of independent PWM audio outputs (1..8).
REQ-002 SHALL have parameter DATA_W, default 16, unsigned offset-binary sample width (8..24).
REQ-003 SHALL have parameter F_CLK, default 100_000_000, system clock frequency in Hz.
REQ-004 SHALL have parameter F_SAMPLE, default 44100, PWM period rate in Hz; PERIOD = F_CLK/F_SAMPLE clocks (2267 by default), PERIOD >= 2.
REQ-005 SHALL have port clk_i, input, 1, the single system clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port s_data_i, input, CHANNELS*DATA_W, packed samples; channel c occupies bits [c*DATA_W +: DATA_W].
REQ-008 SHALL have port s_valid_i, input, 1, sample-set valid.
REQ-009 SHALL have port s_ready_o, output, 1, shadow buffer empty, so a sample set can be accepted.
REQ-010 SHALL have port pwm_o, output, CHANNELS, registered PWM outputs.
REQ-011 SHALL have port period_o, output, 1, one-cycle strobe on each period wrap.
REQ-012 SHALL have port underrun_o, output, 1, one-cycle strobe when a wrap finds the shadow buffer empty.

Function
REQ-013 SHALL run a period counter cnt from 0 to PERIOD-1, then wrap to 0; a wrap cycle is a cycle with cnt == PERIOD-1.
REQ-014 SHALL accept a sample set on a rising edge where s_valid_i && s_ready_o, storing all channels into the shadow register and setting shadow state FULL.
REQ-015 SHALL keep a two-state shadow FSM: EMPTY->FULL on accept; FULL->EMPTY on wrap; otherwise hold. s_ready_o is registered and equals (state == EMPTY).
REQ-016 On a wrap with shadow FULL, SHALL load duty[c] = (shadow[c] * PERIOD) >> DATA_W into the active register, using a full-width product with no truncation before the shift.
REQ-017 On a wrap with shadow EMPTY, SHALL retain the previous duty[c] and pulse underrun_o in that same cycle.
REQ-018 If an accept and a wrap with shadow EMPTY occur in the same cycle, the sample SHALL go to the shadow (state FULL) and SHALL NOT reach duty until the next wrap; underrun_o still pulses.
REQ-019 SHALL register pwm_o[c] <= (cmp[c] < duty[c]), so the output lags cnt by one clock.
REQ-020 Sample 0 SHALL give constant low; sample 2^DATA_W-1 SHALL give PERIOD-1 high clocks per period. pwm_o is never constantly high.
REQ-021 period_o SHALL be registered and high for exactly the one cycle after each wrap cycle.
REQ-022 s_data_i SHALL be ignored while s_ready_o is low; the shadow contents SHALL NOT change while FULL.

Reset
REQ-023 While rst_i is high: cnt = 0, shadow = 0, state EMPTY, duty = 0, pwm_o = 0, period_o = 0, underrun_o = 0, s_ready_o = 1.
REQ-024 Asserting rst_i mid-period SHALL immediately force all outputs to their reset values and discard any buffered sample; counting restarts at cnt = 0 on the first edge after release.

Configuration
REQ-025 With PWM_AUDIO_PHASE_STAGGER_EN defined, cmp[c] SHALL be (cnt + c*(PERIOD/CHANNELS)) mod PERIOD, spreading channel edges across the period.
REQ-026 Without PWM_AUDIO_PHASE_STAGGER_EN, cmp[c] SHALL equal cnt for all channels, so edges are aligned.
REQ-027 Duty values, the handshake and the strobes SHALL be identical in both builds.

Structure
REQ-028 Package pwm_audio_pkg SHALL hold the default constants (F_CLK, F_SAMPLE, DATA_W, CHANNELS), the PERIOD derivation, the counter-width calculation, and a duty-calculation function.
REQ-029 A sub-module pwm_audio_ch SHALL hold one channel's duty register, its compare-offset logic and its output flop; pwm_audio_mc SHALL instantiate it CHANNELS times and own cnt, the shadow FSM and the strobes.
REQ-030 Target size is 150-300 RTL lines total.

Verification
REQ-031 Defaults, one accept of 0x8000/0x8000 before the first wrap -> from the next period, each pwm_o is high for 1133 clocks of 2267; period_o pulses every 2267 clocks.
REQ-032 Samples 0x0000 and 0xFFFF -> pwm_o[0] stays low for the whole period; pwm_o[1] is high for 2266 clocks, then low for 1.
REQ-033 No sample after the first period -> underrun_o pulses at every wrap and the duty stays at its last value; s_ready_o stays 1.
REQ-034 Second s_valid_i while FULL -> s_ready_o = 0, the data is ignored, and the first set appears after the wrap.
REQ-035 Accept in the wrap cycle with shadow EMPTY -> underrun_o = 1, the old duty is kept for one more period, then the new duty loads.
REQ-036 rst_i pulsed at cnt = 1000 with shadow FULL -> pwm_o = 0 and s_ready_o = 1 at once; after release, the first period_o arrives 2267 clocks later with duty 0.
REQ-037 With PWM_AUDIO_PHASE_STAGGER_EN and CHANNELS = 2 -> the rising edges of pwm_o[1] lead those of pwm_o[0] by 1133 clocks.

Source files
------------

// File: rtl/pwm_audio_pkg.sv
// Shared constants, shadow-buffer state type and duty arithmetic for the PWM audio block.
// Build option: define PWM_AUDIO_PHASE_STAGGER_EN to spread channel edges across the period.
package pwm_audio_pkg;

    localparam int unsigned DEF_CHANNELS = 2;
    localparam int unsigned DEF_DATA_W   = 16;
    localparam int unsigned DEF_F_CLK    = 100_000_000;
    localparam int unsigned DEF_F_SAMPLE = 44100;

    typedef enum logic {
        SH_EMPTY = 1'b0,
        SH_FULL  = 1'b1
    } shadow_state_t;

    function automatic int unsigned calc_period(input int unsigned f_clk, input int unsigned f_sample);
        return f_clk / f_sample;
    endfunction

    // Counter holds 0..period-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned period);
        return (period > 2) ? $clog2(period) : 1;
    endfunction

    // Full 64-bit product before the shift so no sample/period combination truncates.
    function automatic logic [31:0] calc_duty(input logic [23:0] sample, input int unsigned period,
                                              input int unsigned data_w);
        logic [63:0] prod;
        prod = 64'(sample) * 64'(period);
        return 32'(prod >> data_w);
    endfunction

endpackage

// File: rtl/pwm_audio_ch.sv
// One PWM channel: duty register loaded at period wrap, compare-phase offset and output flop.
// With PWM_AUDIO_PHASE_STAGGER_EN the compare value is rotated by CH_IDX*(PERIOD/CHANNELS).
module pwm_audio_ch
    import pwm_audio_pkg::*;
#(
    parameter int unsigned CH_IDX   = 0,
    parameter int unsigned CHANNELS = DEF_CHANNELS,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned PERIOD   = calc_period(DEF_F_CLK, DEF_F_SAMPLE),
    parameter int unsigned CW       = cnt_width(PERIOD)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CW-1:0]     cnt,
    input  logic              load,
    input  logic [DATA_W-1:0] sample,
    output logic              pwm
);

`ifdef PWM_AUDIO_PHASE_STAGGER_EN
    localparam bit STAGGER = 1'b1;
`else
    localparam bit STAGGER = 1'b0;
`endif

    localparam int unsigned OFFSET = STAGGER ? CH_IDX * (PERIOD / CHANNELS) : 0;

    logic [CW-1:0] duty;
    logic [CW-1:0] duty_next;
    logic [CW:0]   sum;
    logic [CW-1:0] cmp;

    assign duty_next = CW'(calc_duty(24'(sample), PERIOD, DATA_W));

    // OFFSET < PERIOD, so one conditional subtract gives the modulo.
    assign sum = {1'b0, cnt} + (CW + 1)'(OFFSET);
    assign cmp = (sum >= (CW + 1)'(PERIOD)) ? CW'(sum - (CW + 1)'(PERIOD)) : CW'(sum);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty <= '0;
            pwm  <= 1'b0;
        end else begin
            if (load) begin
                duty <= duty_next;
            end
            pwm <= (cmp < duty);
        end
    end

endmodule

// File: rtl/pwm_audio_mc.sv
// Multi-channel PWM audio output: period counter, single-entry shadow buffer FSM and strobes.
// Build option: PWM_AUDIO_PHASE_STAGGER_EN (compare-phase staggering inside pwm_audio_ch).
module pwm_audio_mc
    import pwm_audio_pkg::*;
#(
    parameter int unsigned CHANNELS = DEF_CHANNELS,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned F_CLK    = DEF_F_CLK,
    parameter int unsigned F_SAMPLE = DEF_F_SAMPLE
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [CHANNELS*DATA_W-1:0] s_data_i,
    input  logic                       s_valid_i,
    output logic                       s_ready_o,
    output logic [CHANNELS-1:0]        pwm_o,
    output logic                       period_o,
    output logic                       underrun_o
);

    localparam int unsigned PERIOD = calc_period(F_CLK, F_SAMPLE);
    localparam int unsigned CW     = cnt_width(PERIOD);

    // Handshake: a sample set transfers on a rising edge with s_valid_i && s_ready_o;
    // s_ready_o is high exactly while the shadow buffer is empty.

    logic [CW-1:0]                cnt;
    logic [CHANNELS*DATA_W-1:0]   shadow;
    shadow_state_t                state;
    logic                         wrap;
    logic                         accept;
    logic                         load;

    assign wrap   = (cnt == CW'(PERIOD - 1));
    assign accept = s_valid_i && s_ready_o;
    assign load   = wrap && (state == SH_FULL);

    // Underrun is flagged in the wrap cycle itself, not one cycle later like period_o.
    assign underrun_o = wrap && (state == SH_EMPTY);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt       <= '0;
            shadow    <= '0;
            state     <= SH_EMPTY;
            s_ready_o <= 1'b1;
            period_o  <= 1'b0;
        end else begin
            cnt      <= wrap ? '0 : cnt + CW'(1);
            period_o <= wrap;
            if (accept) begin
                shadow    <= s_data_i;
                state     <= SH_FULL;
                s_ready_o <= 1'b0;
            end else if (load) begin
                state     <= SH_EMPTY;
                s_ready_o <= 1'b1;
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        pwm_audio_ch #(
            .CH_IDX   (c),
            .CHANNELS (CHANNELS),
            .DATA_W   (DATA_W),
            .PERIOD   (PERIOD),
            .CW       (CW)
        ) u_ch (
            .clk    (clk_i),
            .rst    (rst_i),
            .cnt    (cnt),
            .load   (load),
            .sample (shadow[c*DATA_W +: DATA_W]),
            .pwm    (pwm_o[c])
        );
    end

endmodule

// File: tb/tb_pwm_audio_mc.sv
// Bench for pwm_audio_mc in its default build: per-period high counts, strobes and handshake.
module tb_pwm_audio_mc;

    localparam int CHANNELS = 2;
    localparam int DATA_W   = 16;
    localparam int PERIOD   = 100_000_000 / 44100;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [CHANNELS*DATA_W-1:0] s_data;
    logic                       s_valid;
    logic                       s_ready;
    logic [CHANNELS-1:0]        pwm;
    logic                       period;
    logic                       underrun;

    int n_checks = 0;
    int n_errors = 0;

    // Window record: {underrun count, hi1[11:0], hi0[11:0]}
    logic [24:0] exp_q[$];
    logic [24:0] mon_rec;

    int          b_duty0, b_duty1;
    logic [15:0] b_sh0, b_sh1;
    bit          b_full;

    bit started = 1'b0;
    int w_len = 0, w_hi0 = 0, w_hi1 = 0, w_und = 0;

    always #5 clk = ~clk;

    pwm_audio_mc dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .s_data_i   (s_data),
        .s_valid_i  (s_valid),
        .s_ready_o  (s_ready),
        .pwm_o      (pwm),
        .period_o   (period),
        .underrun_o (underrun)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_duty(input logic [15:0] s);
        longint p;
        p = longint'(s) * longint'(PERIOD);
        return int'(p >> 16);
    endfunction

    // Scoreboard side: one record per complete period, popped at each period_o.
    always @(negedge clk) begin
        if (rst) begin
            started = 1'b0;
            w_len = 0; w_hi0 = 0; w_hi1 = 0; w_und = 0;
        end else begin
            if (period) begin
                if (started) begin
                    check("sb_pending", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        mon_rec = exp_q.pop_front();
                        check("win_len", w_len, PERIOD);
                        check("win_hi0", w_hi0, int'(mon_rec[11:0]));
                        check("win_hi1", w_hi1, int'(mon_rec[23:12]));
                        check("win_underrun", w_und, int'(mon_rec[24]));
                    end
                end
                started = 1'b1;
                w_len = 0; w_hi0 = 0; w_hi1 = 0; w_und = 0;
            end
            w_len++;
            w_hi0 += int'(pwm[0]);
            w_hi1 += int'(pwm[1]);
            w_und += int'(underrun);
        end
    end

    task automatic wait_period(input string tag, input int exp_n, input int exp_und);
        int n;
        int und;
        n = 0;
        und = 0;
        while (n < PERIOD + 5) begin
            @(negedge clk);
            n++;
            und += int'(underrun);
            if (period) break;
        end
        check(tag, n, exp_n);
        check({tag, "_underrun"}, und, exp_und);
    endtask

    // Starts at the negedge of a cnt==0 cycle; ends at the next one.
    // mode 0 idle, 1 accept, 2 accept + ignored second set, 3 accept in wrap cycle, 4 reset mid-period.
    task automatic drive_window(input int mode, input logic [15:0] a0, input logic [15:0] a1);
        logic [24:0] rec;
        bit early;
        early = (mode == 1) || (mode == 2) || (mode == 4);
        rec[11:0]  = 12'(b_duty0);
        rec[23:12] = 12'(b_duty1);
        rec[24]    = 1'b0;
        for (int i = 0; i < PERIOD; i++) begin
            if (early && i == 5) begin
                check("ready_idle", int'(s_ready), int'(!b_full));
                s_data  = {a1, a0};
                s_valid = 1'b1;
                if (!b_full) begin
                    b_sh0 = a0; b_sh1 = a1; b_full = 1'b1;
                end
            end
            if (early && i == 6) begin
                s_valid = 1'b0;
                check("ready_after_accept", int'(s_ready), 0);
            end
            if (mode == 2 && i == 20) begin
                check("ready_while_full", int'(s_ready), 0);
                s_data  = ~{a1, a0};
                s_valid = 1'b1;
            end
            if (mode == 2 && i == 30) s_valid = 1'b0;
            if (mode == 4 && i == 1000) begin
                rst = 1'b1;
                #1;
                check("rst_pwm", int'(pwm), 0);
                check("rst_ready", int'(s_ready), 1);
                check("rst_period", int'(period), 0);
                check("rst_underrun", int'(underrun), 0);
                repeat (3) @(negedge clk);
                rst = 1'b0;
                b_duty0 = 0; b_duty1 = 0; b_full = 1'b0;
                wait_period("rst_first_period", PERIOD, 1);
                return;
            end
            if (i == PERIOD - 1) begin
                check("underrun_at_wrap", int'(underrun), int'(!b_full));
                check("ready_at_wrap", int'(s_ready), int'(!b_full));
                rec[24] = !b_full;
                if (b_full) begin
                    b_duty0 = exp_duty(b_sh0);
                    b_duty1 = exp_duty(b_sh1);
                    b_full  = 1'b0;
                end else if (mode == 3) begin
                    s_data  = {a1, a0};
                    s_valid = 1'b1;
                    b_sh0 = a0; b_sh1 = a1; b_full = 1'b1;
                end
                exp_q.push_back(rec);
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        b_duty0 = 0; b_duty1 = 0; b_sh0 = '0; b_sh1 = '0; b_full = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_pwm", int'(pwm), 0);
        check("reset_ready", int'(s_ready), 1);
        check("reset_period", int'(period), 0);
        check("reset_underrun", int'(underrun), 0);

        rst = 1'b0;
        @(negedge clk);
        s_data  = 32'h8000_8000;
        s_valid = 1'b1;
        b_sh0 = 16'h8000; b_sh1 = 16'h8000; b_full = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        check("ready_first_accept", int'(s_ready), 0);
        wait_period("first_period", PERIOD - 2, 0);
        b_duty0 = exp_duty(b_sh0);
        b_duty1 = exp_duty(b_sh1);
        b_full  = 1'b0;

        drive_window(0, 16'h0000, 16'h0000);
        drive_window(0, 16'h0000, 16'h0000);
        drive_window(1, 16'h0000, 16'hFFFF);
        drive_window(0, 16'h0000, 16'h0000);
        drive_window(2, 16'h4000, 16'hC000);
        drive_window(3, 16'h1234, 16'hFEDC);
        drive_window(0, 16'h0000, 16'h0000);
        drive_window(0, 16'h0000, 16'h0000);
        for (int r = 0; r < 3; r++) begin
            drive_window(1, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
        end
        drive_window(4, 16'h8000, 16'h8000);
        drive_window(0, 16'h0000, 16'h0000);

        repeat (3) @(negedge clk);
        check("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
